move_controller: RTL and testbench

Sequencer that sits directly upstream of the 4x4 node grid. It accepts one move command at a time and injects the ready wavefront into the lead node of every lane. It collects per-lane completion, then spawns a new tile through the nodes' preset path. It also reports win, game-over, move count and a watchdog fault.

---
 rtl/game_pkg.sv | 71 +++++++
 rtl/spawn_lfsr.sv | 26 ++
 rtl/move_controller.sv | 165 ++++++++++++++++
 tb/tb_move_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared constants, direction encodings, controller state enum and
// board-inspection helpers for the 4x4 tile grid and its move controller.
package game_pkg;

  localparam int CELL_W  = 4;
  localparam int GRID_N  = 4;
  localparam int N_CELLS = GRID_N * GRID_N;
  localparam logic [CELL_W-1:0] WIN_CODE = 4'd11;

  // One-hot lane directions as seen on a lead node's ready_from input.
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_INJECT,
    ST_WAIT,
    ST_COMPARE,
    ST_SCAN,
    ST_PRESET,
    ST_CHECK
  } ctrl_state_t;

  // Encoded move direction (0=up, 1=right, 2=down, 3=left) to lane one-hot.
  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    logic [3:0] oh;
    case (dir)
      2'd0:    oh = DIR_UP;
      2'd1:    oh = DIR_RIGHT;
      2'd2:    oh = DIR_DOWN;
      default: oh = DIR_LEFT;
    endcase
    return oh;
  endfunction

  function automatic logic [CELL_W-1:0] cell_at(input logic [N_CELLS*CELL_W-1:0] board,
                                                input int idx);
    return board[idx*CELL_W +: CELL_W];
  endfunction

  function automatic logic board_has_win(input logic [N_CELLS*CELL_W-1:0] board);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (cell_at(board, i) == WIN_CODE) hit = 1'b1;
    end
    return hit;
  endfunction

  // True when no empty cell exists and no orthogonal neighbours could merge.
  function automatic logic board_stuck(input logic [N_CELLS*CELL_W-1:0] board);
    logic any_empty;
    logic any_pair;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        if (cell_at(board, r*GRID_N + c) == '0) any_empty = 1'b1;
        if (c < GRID_N-1 && cell_at(board, r*GRID_N + c) == cell_at(board, r*GRID_N + c + 1))
          any_pair = 1'b1;
        if (r < GRID_N-1 && cell_at(board, r*GRID_N + c) == cell_at(board, (r+1)*GRID_N + c))
          any_pair = 1'b1;
      end
    end
    return !any_empty && !any_pair;
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// spawn_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11) that picks spawn
// cells and tile values. Free-runs every cycle; rst reloads the seed.
module spawn_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rnd
);

  // An all-zero state would lock the register, so a zero seed becomes 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  logic [15:0] state;

  // Right-shifting Galois step; feedback taps applied when the LSB falls out.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    if (rst) state <= SEED_EFF;
    else     state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
  end

  assign rnd = state[7:0];

endmodule

// File: rtl/move_controller.sv
// move_controller: accepts one move at a time, injects the ready wavefront
// into each lane's lead node, collects lane completion, spawns a tile and
// tracks win / game-over / move count.
// Optional: define MOVE_TIMEOUT_EN to enable the WAIT-state watchdog that
// pulses fault and abandons a move after WATCHDOG_CYC cycles.
module move_controller
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          WATCHDOG_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  input  logic [63:0] board_value,
  input  logic [3:0]  lane_done,
  output logic [3:0]  inject_dir,
  output logic [15:0] preset_ext,
  output logic [3:0]  preset_value,
  output logic [15:0] move_count,
  output logic        win,
  output logic        game_over,
  output logic        fault
);

`ifdef MOVE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int              WD_W    = $clog2(WATCHDOG_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYC - 1);

  ctrl_state_t     state;
  logic [1:0]      spawn_cnt;
  logic [63:0]     snapshot;
  logic [3:0]      done_latch;
  logic [3:0]      scan_idx;
  logic [3:0]      scan_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic [7:0]      rnd;
  logic [3:0]      done_next;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  // Latch view including this cycle's pulses, so simultaneous bits all count now.
  assign done_next = done_latch | lane_done;

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      spawn_cnt    <= 2'd2;
      move_ready   <= 1'b0;
      inject_dir   <= '0;
      preset_ext   <= '0;
      preset_value <= '0;
      move_count   <= '0;
      win          <= 1'b0;
      game_over    <= 1'b0;
      fault        <= 1'b0;
      // NOTE: the snapshot is an ordinary register, not a RAM, so it is reset like the rest.
      snapshot     <= '0;
      done_latch   <= '0;
      scan_idx     <= '0;
      scan_cnt     <= '0;
      wd_cnt       <= '0;
    end else begin
      // NOTE: pulse outputs default low here so each is high for exactly one cycle.
      inject_dir   <= '0;
      preset_ext   <= '0;
      preset_value <= '0;
      fault        <= 1'b0;

      case (state)
        ST_INIT: begin
          state    <= ST_SCAN;
          scan_idx <= rnd[3:0];
          scan_cnt <= '0;
        end

        ST_IDLE: begin
          move_ready <= ~game_over;
          if (move_valid && move_ready) begin
            snapshot   <= board_value;
            inject_dir <= dir_onehot(move_dir);
            move_ready <= 1'b0;
            state      <= ST_INJECT;
          end
        end

        ST_INJECT: begin
          // Completions seen while the wavefront is being launched are stale.
          done_latch <= '0;
          wd_cnt     <= '0;
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          done_latch <= done_next;
          if (&done_next) begin
            state <= ST_COMPARE;
          end else if (TIMEOUT_EN && wd_cnt == WD_LAST) begin
            fault      <= 1'b1;
            move_ready <= ~game_over;
            state      <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        ST_COMPARE: begin
          if (board_value != snapshot) begin
            if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
            state    <= ST_SCAN;
            scan_idx <= rnd[3:0];
            scan_cnt <= '0;
          end else begin
            state <= ST_CHECK;
          end
        end

        ST_SCAN: begin
          if (cell_at(board_value, int'(scan_idx)) == '0) begin
            state        <= ST_PRESET;
            preset_ext   <= 16'(1) << scan_idx;
            preset_value <= (rnd[7:4] == 4'd0) ? 4'd2 : 4'd1;
          end else begin
            scan_idx <= scan_idx + 4'd1;
            scan_cnt <= scan_cnt + 4'd1;
            if (scan_cnt == 4'd15) state <= ST_CHECK;
          end
        end

        ST_PRESET: begin
          if (spawn_cnt != 2'd0) spawn_cnt <= spawn_cnt - 2'd1;
          if (spawn_cnt > 2'd1) begin
            state    <= ST_SCAN;
            scan_idx <= rnd[3:0];
            scan_cnt <= '0;
          end else begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (board_has_win(board_value)) win <= 1'b1;
          if (board_stuck(board_value)) game_over <= 1'b1;
          move_ready <= ~(game_over | board_stuck(board_value));
          state      <= ST_IDLE;
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller: directed bench for move_controller. The bench plays the
// grid (board register updated by presets), a scoreboard queue holds expected
// inject/preset events, and a negedge monitor pops and compares them.
module tb_move_controller;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready;
  logic [63:0] board = '0;
  logic [3:0]  lane_done = '0;
  logic [3:0]  inject_dir;
  logic [15:0] preset_ext;
  logic [3:0]  preset_value;
  logic [15:0] move_count;
  logic        win;
  logic        game_over;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {EV_INJECT, EV_PRESET} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [3:0]  dir;
    logic [15:0] mask;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pend_ext = '0;
  logic [3:0]  pend_val = '0;

  always #5 clk = ~clk;

  move_controller dut (
    .clk          (clk),
    .rst          (rst),
    .move_valid   (move_valid),
    .move_dir     (move_dir),
    .move_ready   (move_ready),
    .board_value  (board),
    .lane_done    (lane_done),
    .inject_dir   (inject_dir),
    .preset_ext   (preset_ext),
    .preset_value (preset_value),
    .move_count   (move_count),
    .win          (win),
    .game_over    (game_over),
    .fault        (fault)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] empty_mask(input logic [63:0] b);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (b[4*i +: 4] == 4'd0);
    return m;
  endfunction

  function automatic int count_tiles(input logic [63:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (b[4*i +: 4] != 4'd0) n++;
    return n;
  endfunction

  // Grid model: a preset seen in one cycle lands in the board just after the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && pend_ext != 0) begin
        for (int i = 0; i < 16; i++) if (pend_ext[i]) board[4*i +: 4] = pend_val;
      end
      pend_ext = '0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an inject or a preset.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (inject_dir != 4'd0) begin
        if (sb.size() == 0) begin
          check("unexpected_inject", inject_dir, 4'd0);
        end else begin
          e = sb.pop_front();
          if (e.kind != EV_INJECT) check({e.name, "_got_inject"}, inject_dir, 4'd0);
          else                     check(e.name, inject_dir, e.dir);
        end
      end
      if (preset_ext != 16'd0) begin
        pend_ext = preset_ext;
        pend_val = preset_value;
        if (sb.size() == 0) begin
          check("unexpected_preset", preset_ext, 16'd0);
        end else begin
          e = sb.pop_front();
          if (e.kind != EV_PRESET) begin
            check({e.name, "_got_preset"}, preset_ext, 16'd0);
          end else begin
            if ($onehot(e.mask)) check(e.name, preset_ext, e.mask);
            else begin
              check({e.name, "_onehot"}, $onehot(preset_ext), 1);
              check({e.name, "_cell_empty"}, preset_ext & ~(e.mask & empty_mask(board)), 0);
            end
            check({e.name, "_value"}, (preset_value == 4'd1 || preset_value == 4'd2), 1);
          end
        end
      end else if (preset_value != 4'd0) begin
        check("preset_value_idle", preset_value, 4'd0);
      end
    end
  end

  task automatic wait_ready(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (move_ready) break;
    end
    check({name, "_ready"}, move_ready, 1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, {move_ready, inject_dir, preset_ext, preset_value}, 0);
    check({name, "_status"}, {move_count, win, game_over, fault}, 0);
  endtask

  task automatic do_reset(input string name);
    exp_t e;
    rst = 1'b1;
    board = '0;
    lane_done = '0;
    move_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero({name, "_in_reset"});
    e = '{EV_PRESET, 4'd0, 16'hFFFF, {name, "_spawn1"}};
    sb.push_back(e);
    e = '{EV_PRESET, 4'd0, 16'hFFFF, {name, "_spawn2"}};
    sb.push_back(e);
    rst = 1'b0;
    wait_ready(name, 80);
    check({name, "_tiles"}, count_tiles(board), 2);
    check({name, "_count"}, move_count, 0);
  endtask

  // Presents a move for one cycle; returns at the negedge of the INJECT cycle.
  task automatic issue_move(input logic [1:0] dir, input logic [3:0] exp_dir, input string name);
    exp_t e;
    e = '{EV_INJECT, exp_dir, 16'd0, name};
    sb.push_back(e);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = dir;
    @(negedge clk);
    move_valid = 1'b0;
    check({name, "_busy"}, move_ready, 0);
  endtask

  task automatic pulse_lanes(input logic [3:0] v);
    @(negedge clk);
    lane_done = v;
    @(negedge clk);
    lane_done = '0;
  endtask

  task automatic expect_spawn(input logic [15:0] mask, input string name);
    exp_t e;
    e = '{EV_PRESET, 4'd0, mask, name};
    sb.push_back(e);
  endtask

  initial begin
    int k;

    // Reset state and the two initial spawns.
    do_reset("init");

    // Left move on an unchanged board: no spawn, count stays 0.
    board = 64'h1;
    issue_move(2'd3, DIR_LEFT, "left_same");
    lane_done = 4'hF;              // arrives during INJECT, must be ignored
    @(negedge clk);
    lane_done = '0;
    move_valid = 1'b1;             // not ready: must not be queued
    move_dir   = 2'd0;
    @(negedge clk);
    move_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("left_inject_lanes_ignored", move_ready, 0);
    pulse_lanes(4'hF);
    wait_ready("left_same", 40);
    check("left_same_count", move_count, 0);
    check("left_same_board", board, 64'h1);

    // Right move that changes the board; lanes complete one by one.
    issue_move(2'd1, DIR_RIGHT, "right_change");
    expect_spawn(16'hFFFF, "right_spawn");
    board = 64'h1000;
    pulse_lanes(4'b0001);
    pulse_lanes(4'b0110);
    check("right_partial_lanes", move_ready, 0);
    pulse_lanes(4'b1000);
    wait_ready("right_change", 60);
    check("right_change_count", move_count, 1);
    check("right_change_tiles", count_tiles(board), 2);

    // Only cell 2 empty: wherever the scan starts it must land on cell 2.
    issue_move(2'd0, DIR_UP, "wrap");
    expect_spawn(16'h0004, "wrap_spawn");
    board = 64'h1111_1111_1111_1011;
    pulse_lanes(4'hF);
    wait_ready("wrap", 60);
    check("wrap_count", move_count, 2);
    check("wrap_tiles", count_tiles(board), 16);
    check("wrap_not_over", game_over, 0);

    // Board containing code 11 sets win.
    issue_move(2'd2, DIR_DOWN, "win_move");
    expect_spawn(16'hFFFE, "win_spawn");
    board = 64'h0000_0000_0000_000B;
    pulse_lanes(4'hF);
    wait_ready("win_move", 60);
    check("win_flag", win, 1);
    check("win_not_over", game_over, 0);
    check("win_count", move_count, 3);

    // Full checkerboard with no merges: 16-cycle scan, no spawn, game over.
    issue_move(2'd3, DIR_LEFT, "full");
    board = 64'h1212_2121_1212_2121;
    pulse_lanes(4'hF);
    repeat (40) @(negedge clk);
    check("full_game_over", game_over, 1);
    check("full_not_ready", move_ready, 0);
    check("full_win_sticky", win, 1);
    check("full_count", move_count, 4);
    move_valid = 1'b1;
    repeat (3) @(negedge clk);
    move_valid = 1'b0;
    check("full_still_not_ready", move_ready, 0);

    // Reset asserted mid-move (in WAIT) clears every output at the next edge.
    do_reset("reinit");
    issue_move(2'd0, DIR_UP, "pre_rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    board = '0;
    @(negedge clk);
    check_outputs_zero("mid_move_rst");
    do_reset("post_rst");

    // Three of four lanes complete: watchdog (if built) or indefinite hold.
    issue_move(2'd1, DIR_RIGHT, "wd");
    lane_done = 4'b0111;
`ifdef MOVE_TIMEOUT_EN
    k = 1;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (fault) break;
    end
    check("wd_fault_latency", k, 64 + 2);
    check("wd_ready", move_ready, 1);
    check("wd_count", move_count, 0);
    @(negedge clk);
    check("wd_fault_pulse", fault, 0);
    lane_done = '0;
    check("wd_no_spawn", count_tiles(board), 2);
`else
    k = 0;
    repeat (100) @(negedge clk);
    check("hold_no_fault", fault, 0);
    check("hold_waiting", move_ready, 0);
    lane_done = 4'hF;
    @(negedge clk);
    lane_done = '0;
    wait_ready("hold", 40);
    check("hold_count", move_count, 0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
